lcd_host: RTL and testbench

Host-side counterpart of the LCD controller. It models the image ROM the controller reads, issues a preloaded script of 4-bit commands over the `cmd`/`cmd_valid`/`busy` handshake, and captures every IRAM write into an internal 64x8 result buffer for readback. It sits between a test or system wrapper and the LCD controller, on the far end of every controller port.

---
 rtl/lcd_host_if.sv | 26 ++
 rtl/lcd_host.sv | 155 +++++++++++++++
 tb/tb_lcd_host.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_host_if.sv
// Controller-facing bus of lcd_host: image ROM reads,
// the cmd/busy handshake and the IRAM result writes.
interface lcd_host_if;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       done;

    modport master (
        output IROM_Q, cmd, cmd_valid,
        input  IROM_rd, IROM_A, busy,
        input  IRAM_valid, IRAM_A, IRAM_D, done
    );

    modport slave (
        input  IROM_Q, cmd, cmd_valid,
        output IROM_rd, IROM_A, busy,
        output IRAM_valid, IRAM_A, IRAM_D, done
    );
endinterface

// File: rtl/lcd_host.sv
// Host side of the LCD controller: image ROM, scripted command
// issue over cmd/busy, and capture of IRAM writes for readback.
module lcd_host #(
    parameter int CMD_DEPTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rom_we,
    input  logic [5:0]                   rom_wa,
    input  logic [7:0]                   rom_wd,
    input  logic                         scr_we,
    input  logic [$clog2(CMD_DEPTH)-1:0] scr_wa,
    input  logic [3:0]                   scr_wd,
    input  logic [5:0]                   num_cmds,
    input  logic                         start,
    lcd_host_if.master                   bus,
    input  logic [5:0]                   rd_addr,
    output logic [7:0]                   rd_data,
    output logic [6:0]                   wr_count,
    output logic                         lcd_done_seen,
    output logic                         host_done,
    output logic                         err
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, ISSUE, WAIT_HI, WAIT_LO, FINISH
    } state_t;

    state_t        state;
    logic [7:0]    rom [64];
    logic [3:0]    scr [CMD_DEPTH];
    logic [7:0]    ram [64];
    logic [5:0]    idx;
    logic [5:0]    n_cmds;
    logic [TW-1:0] tmr;
    logic [3:0]    cmd_q;
    logic          cmd_valid_q;
    logic          start_ok;
    logic          unused_rd;

    // The controller latches IROM_Q on the edge it presents IROM_A,
    // so the ROM read must be purely combinational.
    assign bus.IROM_Q    = rom[bus.IROM_A];
    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign rd_data       = ram[rd_addr];
    assign unused_rd     = bus.IROM_rd;
    assign start_ok      = start && (state == IDLE || state == FINISH);

    // Image ROM load; contents survive reset.
    always_ff @(posedge clk) begin
        if (rom_we) rom[rom_wa] <= rom_wd;
    end

    // Command script load.
    always_ff @(posedge clk) begin
        if (scr_we) scr[scr_wa] <= scr_wd;
    end

    // Result capture; reset blocks a simultaneous write.
    always_ff @(posedge clk) begin
        if (!reset && bus.IRAM_valid) ram[bus.IRAM_A] <= bus.IRAM_D;
    end

    // Write counter and sticky done flag, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            wr_count      <= 7'd0;
            lcd_done_seen <= 1'b0;
        end else begin
            if (bus.IRAM_valid && wr_count != 7'd127)
                wr_count <= wr_count + 7'd1;
            if (bus.done)
                lcd_done_seen <= 1'b1;
        end
    end

    // Script sequencer with per-state timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 6'd0;
            n_cmds      <= 6'd0;
            tmr         <= '0;
            cmd_q       <= 4'd0;
            cmd_valid_q <= 1'b0;
            host_done   <= 1'b0;
            err         <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            tmr         <= tmr + TW'(1);
            unique case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        n_cmds    <= num_cmds;
                        idx       <= 6'd0;
                        err       <= 1'b0;
                        tmr       <= '0;
                        host_done <= (num_cmds == 6'd0);
                        state     <= (num_cmds == 6'd0) ? FINISH : WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (!bus.busy) begin
                        cmd_q       <= scr[idx[AW-1:0]];
                        cmd_valid_q <= 1'b1;
                        tmr         <= '0;
                        state       <= ISSUE;
                    end else if (tmr >= TW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        host_done <= 1'b1;
                        tmr       <= '0;
                        state     <= FINISH;
                    end
                end
                ISSUE: begin
                    tmr   <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.busy) begin
                        tmr   <= '0;
                        state <= WAIT_LO;
                    end else if (tmr >= TW'(3)) begin
                        err       <= 1'b1;
                        host_done <= 1'b1;
                        tmr       <= '0;
                        state     <= FINISH;
                    end
                end
                WAIT_LO: begin
                    if (!bus.busy) begin
                        idx <= idx + 6'd1;
                        tmr <= '0;
                        if (idx + 6'd1 == n_cmds) begin
                            host_done <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end else if (tmr >= TW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        host_done <= 1'b1;
                        tmr       <= '0;
                        state     <= FINISH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_host.sv
// Testbench for lcd_host: scripted controller model, scoreboard
// of issued commands, ROM/RAM service and timeout scenarios.
module tb_lcd_host;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rom_we = 1'b0;
    logic [5:0] rom_wa = '0;
    logic [7:0] rom_wd = '0;
    logic       scr_we = 1'b0;
    logic [3:0] scr_wa = '0;
    logic [3:0] scr_wd = '0;
    logic [5:0] num_cmds = '0;
    logic       start = 1'b0;
    logic [5:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [6:0] wr_count;
    logic       lcd_done_seen;
    logic       host_done;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q [$];
    logic [3:0] got_q [$];
    bit         model_en = 0;
    bit         wr_en = 0;
    int         busy_len = 1;
    int         cv_cycles = 0;
    int         stab_viol = 0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_cmd = '0;

    lcd_host_if bus ();

    lcd_host #(.CMD_DEPTH(16), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset),
        .rom_we(rom_we), .rom_wa(rom_wa), .rom_wd(rom_wd),
        .scr_we(scr_we), .scr_wa(scr_wa), .scr_wd(scr_wd),
        .num_cmds(num_cmds), .start(start), .bus(bus.master),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count),
        .lcd_done_seen(lcd_done_seen), .host_done(host_done), .err(err)
    );

    always #5 clk = ~clk;

    // Controller model: accepts cmd_valid, raises busy one cycle later.
    initial begin : ctrl_model
        logic [3:0] c;
        forever begin
            @(negedge clk);
            if (model_en && bus.cmd_valid) begin
                c = bus.cmd;
                got_q.push_back(c);
                @(posedge clk);
                @(posedge clk);
                #1 bus.busy = 1'b1;
                if (c == 4'h0 && wr_en) begin
                    for (int i = 0; i < 64; i++) begin
                        bus.IRAM_valid = 1'b1;
                        bus.IRAM_A = 6'(i);
                        bus.IRAM_D = 8'(i) ^ 8'hFF;
                        @(posedge clk);
                        #1;
                    end
                    bus.IRAM_valid = 1'b0;
                    bus.done = 1'b1;
                    @(posedge clk);
                    #1 bus.done = 1'b0;
                end else begin
                    repeat (busy_len) @(posedge clk);
                    #1;
                end
                bus.busy = 1'b0;
            end
        end
    end

    // Observes cmd_valid width and cmd stability under busy.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.cmd_valid) cv_cycles++;
            if (bus.busy && prev_busy && bus.cmd !== prev_cmd) stab_viol++;
            prev_busy = bus.busy;
            prev_cmd = bus.cmd;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [5:0] n);
        @(negedge clk);
        num_cmds = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_script(input logic [15:0] s);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            scr_we = 1'b1;
            scr_wa = 4'(i);
            scr_wd = s[15 - 4*i -: 4];
        end
        @(negedge clk);
        scr_we = 1'b0;
    endtask

    task automatic wait_host_done(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (host_done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_cv(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.cmd_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.cmd, bus.cmd_valid, wr_count, lcd_done_seen, host_done, err} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs cmd=%0h cv=%0b wc=%0d ds=%0b hd=%0b err=%0b required all 0",
                     bus.cmd, bus.cmd_valid, wr_count, lcd_done_seen, host_done, err);
        end
    endtask

    task automatic test_rom();
        logic [7:0] e;
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            rom_we = 1'b1;
            rom_wa = 6'(a);
            rom_wd = 8'(a * 3);
        end
        @(negedge clk);
        rom_we = 1'b0;
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            bus.IROM_A = 6'(a);
            bus.IROM_rd = a[0];
            #1;
            e = 8'(a * 3);
            checks++;
            if (bus.IROM_Q !== e) begin
                errors++;
                $display("FAIL rom_read a=%0d got=%0d required=%0d", a, bus.IROM_Q, e);
            end
        end
        bus.IROM_A = 6'd63;
        #1;
        checks++;
        if (bus.IROM_Q !== 8'd189) begin
            errors++;
            $display("FAIL rom_top got=%0d required=189", bus.IROM_Q);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [3:0] g;
        load_script(16'h1000);
        model_en = 1;
        wr_en = 0;
        busy_len = 1;
        cv_cycles = 0;
        stab_viol = 0;
        exp_q.push_back(4'h1);
        pulse_start(6'd1);
        wait_host_done(200, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done got=timeout required=host_done");
        end
        checks++;
        if (cv_cycles !== 1) begin
            errors++;
            $display("FAIL single_cv_width got=%0d required=1", cv_cycles);
        end
        while (exp_q.size() > 0) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            checks++;
            if (g !== exp_q[0]) begin
                errors++;
                $display("FAIL single_cmd got=%0h required=%0h", g, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        checks++;
        if (stab_viol !== 0 || host_done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_status stab=%0d hd=%0b err=%0b required 0/1/0",
                     stab_viol, host_done, err);
        end
        model_en = 0;
    endtask

    task automatic test_script();
        bit ok;
        logic [3:0] g;
        logic [7:0] e;
        load_script(16'h3450);
        model_en = 1;
        wr_en = 1;
        busy_len = 2;
        stab_viol = 0;
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h4);
        exp_q.push_back(4'h5);
        exp_q.push_back(4'h0);
        pulse_start(6'd4);
        wait_host_done(1000, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL script_done got=timeout required=host_done");
        end
        while (exp_q.size() > 0) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            checks++;
            if (g !== exp_q[0]) begin
                errors++;
                $display("FAIL script_cmd got=%0h required=%0h", g, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        checks++;
        if (wr_count !== 7'd64 || lcd_done_seen !== 1'b1 || err !== 1'b0 || stab_viol !== 0) begin
            errors++;
            $display("FAIL script_status wc=%0d ds=%0b err=%0b stab=%0d required 64/1/0/0",
                     wr_count, lcd_done_seen, err, stab_viol);
        end
        rd_addr = 6'd10;
        #1;
        checks++;
        if (rd_data !== 8'hF5) begin
            errors++;
            $display("FAIL rd_data10 got=%0h required=f5", rd_data);
        end
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            #1;
            e = 8'(a) ^ 8'hFF;
            checks++;
            if (rd_data !== e) begin
                errors++;
                $display("FAIL rd_data a=%0d got=%0h required=%0h", a, rd_data, e);
            end
        end
        // Restart directly from FINISH with a shorter script.
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h4);
        pulse_start(6'd2);
        checks++;
        if (wr_count !== 7'd0 || lcd_done_seen !== 1'b0 || host_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear wc=%0d ds=%0b hd=%0b required 0/0/0",
                     wr_count, lcd_done_seen, host_done);
        end
        wait_host_done(500, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || got_q.size() !== 2) begin
            errors++;
            $display("FAIL restart_done ok=%0b n=%0d required 1/2", ok, got_q.size());
        end
        while (exp_q.size() > 0) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            checks++;
            if (g !== exp_q[0]) begin
                errors++;
                $display("FAIL restart_cmd got=%0h required=%0h", g, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        got_q.delete();
        model_en = 0;
        wr_en = 0;
    endtask

    task automatic test_zero_cmds();
        cv_cycles = 0;
        pulse_start(6'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (host_done !== 1'b1 || cv_cycles !== 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_cmds hd=%0b cv=%0d err=%0b required 1/0/0",
                     host_done, cv_cycles, err);
        end
    endtask

    task automatic test_busy_at_start();
        bit any_cv;
        bus.busy = 1'b1;
        do_reset();
        pulse_start(6'd4);
        any_cv = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.cmd_valid) any_cv = 1;
        end
        checks++;
        if (any_cv !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold_cv got=1 required=0");
        end
        bus.busy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd !== 4'h3) begin
            errors++;
            $display("FAIL busy_release cv=%0b cmd=%0h required 1/3", bus.cmd_valid, bus.cmd);
        end
    endtask

    task automatic test_timeout_no_busy();
        bit ok;
        do_reset();
        bus.busy = 1'b0;
        pulse_start(6'd1);
        wait_cv(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL nobusy_issue got=timeout required=cmd_valid");
        end
        repeat (4) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL nobusy_early err=%0b required=0", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || host_done !== 1'b1) begin
            errors++;
            $display("FAIL nobusy_timeout err=%0b hd=%0b required 1/1", err, host_done);
        end
    endtask

    task automatic test_timeout_stuck();
        bit ok;
        do_reset();
        pulse_start(6'd1);
        wait_cv(20, ok);
        @(negedge clk);
        bus.busy = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (!ok || err !== 1'b0 || host_done !== 1'b0) begin
            errors++;
            $display("FAIL stuck_early ok=%0b err=%0b hd=%0b required 1/0/0", ok, err, host_done);
        end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || host_done !== 1'b1) begin
            errors++;
            $display("FAIL stuck_timeout err=%0b hd=%0b required 1/1", err, host_done);
        end
        bus.busy = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [3:0] g;
        do_reset();
        pulse_start(6'd4);
        wait_cv(20, ok);
        @(negedge clk);
        bus.busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.IRAM_valid = 1'b1;
            bus.IRAM_A = 6'(i);
            bus.IRAM_D = 8'(i);
        end
        @(negedge clk);
        bus.IRAM_valid = 1'b0;
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        checks++;
        if (!ok || wr_count !== 7'd3 || lcd_done_seen !== 1'b1 || bus.cmd !== 4'h3) begin
            errors++;
            $display("FAIL mid_before ok=%0b wc=%0d ds=%0b cmd=%0h required 1/3/1/3",
                     ok, wr_count, lcd_done_seen, bus.cmd);
        end
        reset = 1'b1;
        bus.IRAM_valid = 1'b1;
        bus.IRAM_A = 6'd20;
        bus.IRAM_D = 8'h5A;
        @(negedge clk);
        reset = 1'b0;
        bus.IRAM_valid = 1'b0;
        bus.busy = 1'b0;
        checks++;
        if ({bus.cmd, bus.cmd_valid, wr_count, lcd_done_seen, host_done, err} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset cmd=%0h cv=%0b wc=%0d ds=%0b hd=%0b err=%0b required all 0",
                     bus.cmd, bus.cmd_valid, wr_count, lcd_done_seen, host_done, err);
        end
        rd_addr = 6'd20;
        #1;
        checks++;
        if (rd_data !== 8'hEB) begin
            errors++;
            $display("FAIL reset_blocks_write got=%0h required=eb", rd_data);
        end
        got_q.delete();
        model_en = 1;
        busy_len = 1;
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h4);
        exp_q.push_back(4'h5);
        exp_q.push_back(4'h0);
        pulse_start(6'd4);
        wait_host_done(500, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || err !== 1'b0) begin
            errors++;
            $display("FAIL rerun_done ok=%0b err=%0b required 1/0", ok, err);
        end
        while (exp_q.size() > 0) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            checks++;
            if (g !== exp_q[0]) begin
                errors++;
                $display("FAIL rerun_cmd got=%0h required=%0h", g, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        model_en = 0;
    endtask

    initial begin
        bus.IROM_rd = 1'b0;
        bus.IROM_A = '0;
        bus.busy = 1'b0;
        bus.IRAM_valid = 1'b0;
        bus.IRAM_A = '0;
        bus.IRAM_D = '0;
        bus.done = 1'b0;
        test_reset();
        test_rom();
        test_single();
        test_script();
        test_zero_cmds();
        test_busy_at_start();
        test_timeout_no_busy();
        test_timeout_stuck();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
